// File: rtl/id_stage_ctrl_pkg.sv
// Shared decode constants for the ID stage: opcode/funct values, ALU codes,
// control-bundle bit positions, immediate modes and FSM state encoding.
package id_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;

    localparam int CTRL_W           = 12;
    localparam int CTRL_ALU_LO      = 0;
    localparam int CTRL_ALU_HI      = 3;
    localparam int CTRL_ALU_SRC_IMM = 4;
    localparam int CTRL_MEM_RD      = 5;
    localparam int CTRL_MEM_WR      = 6;
    localparam int CTRL_REG_WR      = 7;
    localparam int CTRL_MEM_TO_REG  = 8;
    localparam int CTRL_REG_DST_RD  = 9;
    localparam int CTRL_BRANCH      = 10;
    localparam int CTRL_BRANCH_NE   = 11;

    typedef enum logic [1:0] {
        IMM_SIGN  = 2'd0,
        IMM_ZERO  = 2'd1,
        IMM_UPPER = 2'd2
    } imm_mode_t;

    localparam logic [1:0] ST_RUN       = 2'd0;
    localparam logic [1:0] ST_HOLD      = 2'd1;
    localparam logic [1:0] ST_INTERLOCK = 2'd2;

endpackage

// File: rtl/id_stage_ctrl_if.sv
// Fetch-side and execute-side signals of the decode stage, bundled for port use.
interface id_stage_ctrl_if
    import id_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic              if_valid;
    logic [31:0]       if_instr;
    logic [DATA_W-1:0] if_pc4;
    logic              flush;
    logic              ex_ready;
    logic              id_stall;
    logic              ex_valid;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [DATA_W-1:0] ex_imm;
    logic [REG_W-1:0]  ex_rs;
    logic [REG_W-1:0]  ex_rt;
    logic [REG_W-1:0]  ex_rd;
    logic [4:0]        ex_shamt;
    logic [DATA_W-1:0] ex_pc4;
    logic              illegal;

    modport slave (
        input  if_valid, if_instr, if_pc4, flush, ex_ready,
        output id_stall, ex_valid, ex_ctrl, ex_imm, ex_rs, ex_rt, ex_rd,
               ex_shamt, ex_pc4, illegal
    );

    modport master (
        output if_valid, if_instr, if_pc4, flush, ex_ready,
        input  id_stall, ex_valid, ex_ctrl, ex_imm, ex_rs, ex_rt, ex_rd,
               ex_shamt, ex_pc4, illegal
    );
endinterface

// File: rtl/id_stage_ctrl_imm_extend.sv
// Combinational 16-bit immediate extension: sign, zero or upper-half placement.
module imm_extend
    import id_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [15:0]       imm,
    input  imm_mode_t         mode,
    output logic [DATA_W-1:0] ext
);
    always_comb begin
        ext = '0;
        case (mode)
            IMM_ZERO:  ext[15:0] = imm;
            IMM_UPPER: ext[31:16] = imm;
            default:   ext = {{(DATA_W-16){imm[15]}}, imm};
        endcase
    end
endmodule

// File: rtl/id_stage_ctrl.sv
// Decode-stage controller: instruction decode, load-use interlock, EX backpressure
// hold, branch flush and the ID/EX pipeline register.
module id_stage_ctrl
    import id_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    id_stage_ctrl_if.slave bus
);
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [REG_W-1:0]  rs_f;
    logic [REG_W-1:0]  rt_f;
    logic [REG_W-1:0]  rd_f;
    logic [4:0]        shamt_f;
    logic [15:0]       imm_f;

    assign opcode  = bus.if_instr[31:26];
    assign rs_f    = bus.if_instr[21 +: REG_W];
    assign rt_f    = bus.if_instr[16 +: REG_W];
    assign rd_f    = bus.if_instr[11 +: REG_W];
    assign shamt_f = bus.if_instr[10:6];
    assign funct   = bus.if_instr[5:0];
    assign imm_f   = bus.if_instr[15:0];

    logic [CTRL_W-1:0] dec_ctrl;
    logic              dec_legal;
    logic              dec_reads_rt;
    imm_mode_t         dec_imm_mode;

    always_comb begin
        dec_ctrl     = '0;
        dec_legal    = 1'b1;
        dec_reads_rt = 1'b0;
        dec_imm_mode = IMM_SIGN;
        case (opcode)
            OP_RTYPE: begin
                dec_ctrl[CTRL_REG_DST_RD] = 1'b1;
                dec_ctrl[CTRL_REG_WR]     = 1'b1;
                dec_reads_rt              = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: dec_ctrl[CTRL_ALU_HI:CTRL_ALU_LO] = ALU_ADD;
                    FN_SUB, FN_SUBU: dec_ctrl[CTRL_ALU_HI:CTRL_ALU_LO] = ALU_SUB;
                    FN_AND:          dec_ctrl[CTRL_ALU_HI:CTRL_ALU_LO] = ALU_AND;
                    FN_OR:           dec_ctrl[CTRL_ALU_HI:CTRL_ALU_LO] = ALU_OR;
                    FN_XOR:          dec_ctrl[CTRL_ALU_HI:CTRL_ALU_LO] = ALU_XOR;
                    FN_NOR:          dec_ctrl[CTRL_ALU_HI:CTRL_ALU_LO] = ALU_NOR;
                    FN_SLT:          dec_ctrl[CTRL_ALU_HI:CTRL_ALU_LO] = ALU_SLT;
                    FN_SLTU:         dec_ctrl[CTRL_ALU_HI:CTRL_ALU_LO] = ALU_SLTU;
                    FN_SLL:          dec_ctrl[CTRL_ALU_HI:CTRL_ALU_LO] = ALU_SLL;
                    FN_SRL:          dec_ctrl[CTRL_ALU_HI:CTRL_ALU_LO] = ALU_SRL;
                    FN_SRA:          dec_ctrl[CTRL_ALU_HI:CTRL_ALU_LO] = ALU_SRA;
                    default:         dec_legal = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                dec_ctrl[CTRL_ALU_SRC_IMM] = 1'b1;
                dec_ctrl[CTRL_REG_WR]      = 1'b1;
                case (opcode)
                    OP_SLTI:  dec_ctrl[CTRL_ALU_HI:CTRL_ALU_LO] = ALU_SLT;
                    OP_SLTIU: dec_ctrl[CTRL_ALU_HI:CTRL_ALU_LO] = ALU_SLTU;
                    default:  dec_ctrl[CTRL_ALU_HI:CTRL_ALU_LO] = ALU_ADD;
                endcase
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                dec_ctrl[CTRL_ALU_SRC_IMM] = 1'b1;
                dec_ctrl[CTRL_REG_WR]      = 1'b1;
                dec_imm_mode               = IMM_ZERO;
                case (opcode)
                    OP_ANDI: dec_ctrl[CTRL_ALU_HI:CTRL_ALU_LO] = ALU_AND;
                    OP_ORI:  dec_ctrl[CTRL_ALU_HI:CTRL_ALU_LO] = ALU_OR;
                    default: dec_ctrl[CTRL_ALU_HI:CTRL_ALU_LO] = ALU_XOR;
                endcase
            end
            OP_LUI: begin
                // lui is an add of the upper-placed immediate to rs ($0 by encoding)
                dec_ctrl[CTRL_ALU_HI:CTRL_ALU_LO] = ALU_ADD;
                dec_ctrl[CTRL_ALU_SRC_IMM]        = 1'b1;
                dec_ctrl[CTRL_REG_WR]             = 1'b1;
                dec_imm_mode                      = IMM_UPPER;
            end
            OP_LW: begin
                dec_ctrl[CTRL_ALU_HI:CTRL_ALU_LO] = ALU_ADD;
                dec_ctrl[CTRL_ALU_SRC_IMM]        = 1'b1;
                dec_ctrl[CTRL_MEM_RD]             = 1'b1;
                dec_ctrl[CTRL_REG_WR]             = 1'b1;
                dec_ctrl[CTRL_MEM_TO_REG]         = 1'b1;
            end
            OP_SW: begin
                dec_ctrl[CTRL_ALU_HI:CTRL_ALU_LO] = ALU_ADD;
                dec_ctrl[CTRL_ALU_SRC_IMM]        = 1'b1;
                dec_ctrl[CTRL_MEM_WR]             = 1'b1;
                dec_reads_rt                      = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                dec_ctrl[CTRL_ALU_HI:CTRL_ALU_LO] = ALU_SUB;
                dec_ctrl[CTRL_BRANCH]             = 1'b1;
                dec_ctrl[CTRL_BRANCH_NE]          = (opcode == OP_BNE);
                dec_reads_rt                      = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
        if (!dec_legal) begin
            dec_ctrl = '0;
        end
    end

    logic [DATA_W-1:0] ext_imm;

    imm_extend #(.DATA_W(DATA_W)) u_imm_extend (
        .imm  (imm_f),
        .mode (dec_imm_mode),
        .ext  (ext_imm)
    );

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       load_use;
    logic       hold_req;
    logic       interlock_req;
    logic       freeze;
    logic       take;
    logic       load;

    assign load_use = bus.ex_valid & bus.ex_ctrl[CTRL_MEM_RD] & (bus.ex_rt != '0) &
                      ((bus.ex_rt == rs_f) | (dec_reads_rt & (bus.ex_rt == rt_f)));

    // HOLD tracks ex_valid & !ex_ready directly, so a held stage advances on
    // the same edge ex_ready returns, with the hazard re-evaluated then.
    assign hold_req      = bus.ex_valid & ~bus.ex_ready;
    assign interlock_req = (state != ST_INTERLOCK) & bus.if_valid & load_use;
    assign bus.id_stall  = ~bus.flush & (hold_req | interlock_req);

    assign freeze = ~bus.flush & hold_req;
    assign take   = ~bus.flush & ~hold_req & ~interlock_req & bus.if_valid;
    assign load   = take & dec_legal;

    always_comb begin
        state_nxt = ST_RUN;
        if (bus.flush) begin
            state_nxt = ST_RUN;
        end else if (hold_req) begin
            state_nxt = ST_HOLD;
        end else if (interlock_req) begin
            state_nxt = ST_INTERLOCK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_RUN;
            bus.ex_valid <= 1'b0;
            bus.ex_ctrl  <= '0;
            bus.ex_imm   <= '0;
            bus.ex_rs    <= '0;
            bus.ex_rt    <= '0;
            bus.ex_rd    <= '0;
            bus.ex_shamt <= '0;
            bus.ex_pc4   <= '0;
            bus.illegal  <= 1'b0;
        end else begin
            state       <= state_nxt;
            bus.illegal <= take & ~dec_legal;
            if (load) begin
                bus.ex_valid <= 1'b1;
                bus.ex_ctrl  <= dec_ctrl;
                bus.ex_imm   <= ext_imm;
                bus.ex_rs    <= rs_f;
                bus.ex_rt    <= rt_f;
                bus.ex_rd    <= rd_f;
                bus.ex_shamt <= shamt_f;
                bus.ex_pc4   <= bus.if_pc4;
            end else if (!freeze) begin
                bus.ex_valid <= 1'b0;
                bus.ex_ctrl  <= '0;
                bus.ex_imm   <= '0;
                bus.ex_rs    <= '0;
                bus.ex_rt    <= '0;
                bus.ex_rd    <= '0;
                bus.ex_shamt <= '0;
                bus.ex_pc4   <= '0;
            end
        end
    end
endmodule

// File: doc/id_stage_ctrl.md
# id_stage_ctrl

Decode-stage controller for the 4-stage MIPS pipeline. It accepts one fetched instruction per cycle and decodes opcode/funct into execute-stage control. It sequences immediate extension (sign, zero or upper) and owns the ID/EX pipeline register. It also enforces load-use interlock, backpressure hold and branch flush, stalling fetch when the instruction cannot advance.

## Interface
Parameters:
- DATA_W, 32, datapath and immediate output width (only 32 supported)
- REG_W, 5, register-specifier width

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_valid  in  1  IF/ID holds a valid instruction
- if_instr  in  32  instruction word
- if_pc4  in  32  PC+4 of that instruction
- flush  in  1  branch taken in EX; squash ID and ID/EX contents
- ex_ready  in  1  EX accepts the current ID/EX contents this cycle
- id_stall  out  1  hold PC and IF/ID (combinational)
- ex_valid  out  1  ID/EX holds a valid instruction
- ex_ctrl  out  12  control bundle (bit map below)
- ex_imm  out  32  extended immediate
- ex_rs, ex_rt, ex_rd  out  5 each  register specifiers
- ex_shamt  out  5  shift amount
- ex_pc4  out  32  registered PC+4
- illegal  out  1  one-cycle pulse, unsupported encoding dropped

## Operation
- ex_ctrl fields:
  - [3:0] alu_op
  - [4] alu_src_imm
  - [5] mem_rd
  - [6] mem_wr
  - [7] reg_wr
  - [8] mem_to_reg
  - [9] reg_dst_rd
  - [10] branch
  - [11] branch_ne
- Immediate mode, with imm = instr[15:0]:
  - SIGN gives {16{imm[15]}, imm}: addi 0x08, addiu 0x09, slti 0x0A, sltiu 0x0B, lw 0x23, sw 0x2B, beq 0x04, bne 0x05.
  - ZERO gives {16'h0, imm}: andi 0x0C, ori 0x0D, xori 0x0E.
  - UPPER gives {imm, 16'h0}: lui 0x0F, decoded as ADD with alu_src_imm.
- R-type (opcode 0):
  - Supported funct values: 0x20/0x21 ADD, 0x22/0x23 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT, 0x2B SLTU, 0x00 SLL, 0x02 SRL, 0x03 SRA.
  - R-type sets reg_dst_rd=1 and reg_wr=1.
- Any other opcode/funct is illegal:
  - The instruction is consumed, not stalled.
  - ID/EX loads a bubble (ex_valid=0).
  - illegal pulses on the cycle the bubble is loaded.
- Bubble definition: ex_valid=0 and ex_ctrl=0. The other ID/EX fields are don't-care but must be driven deterministically, not left as X.
- Reading rt: R-type, beq, bne and sw read rt; every other opcode reads only rs.
- Load-use hazard: ex_valid & ex_ctrl[5] & ex_rt≠0 & (ex_rt==rs, or ex_rt==rt when rt is read).
- FSM states:
  - RUN: normal operation.
  - HOLD: entered when ex_valid & !ex_ready.
    - ID/EX frozen; id_stall=1.
    - Returns to RUN on ex_ready.
  - INTERLOCK: entered from RUN on a load-use hazard with if_valid.
    - Bubble is loaded into ID/EX; id_stall=1 for exactly one cycle.
    - Returns to RUN unconditionally.
- Priority: flush > rst_n-independent HOLD > load-use > normal advance.
- flush:
  - Next edge: ID/EX becomes a bubble, the FSM goes to RUN, id_stall=0.
  - flush overrides HOLD; the held instruction is discarded.
- No accept while in HOLD. if_valid=0 in RUN loads a bubble.

## Timing
- Reset (asynchronous, immediate):
  - ex_valid=0, ex_ctrl=0, ex_imm=0, ex_rs/rt/rd/shamt=0, ex_pc4=0, illegal=0.
  - FSM=RUN.
  - id_stall deasserts once the state settles.
- Reset mid-INTERLOCK or mid-HOLD discards all state. The first post-reset instruction decodes normally.
- Latency: an instruction accepted at edge N appears on ex_* after edge N, one cycle.
- Throughput: one instruction per cycle with no hazards and ex_ready=1.
- id_stall:
  - Combinational from FSM state, ID/EX contents, if_instr and ex_ready.
  - Forced 0 when flush=1.
- Load-use costs exactly one bubble. The stalled instruction advances on the following edge.
- Simultaneous HOLD and load-use: HOLD wins. The hazard is re-evaluated when ex_ready returns.

## Structure
- Package id_pkg:
  - opcode and funct localparams
  - alu_op encoding: ADD 0, SUB 1, AND 2, OR 3, XOR 4, NOR 5, SLT 6, SLTU 7, SLL 8, SRL 9, SRA 10
  - ex_ctrl bit indices
  - imm-mode encoding (SIGN/ZERO/UPPER)
  - FSM state encoding
- One sub-module: imm_extend. It is combinational, takes imm[15:0] and a mode, and returns 32 bits; it generalises the existing sign extension. The FSM, hazard detect and ID/EX register stay in id_stage_ctrl.

## Test plan
- Immediate modes:
  - addi $1,$0,0x8000 -> ex_imm=0xFFFF8000, alu_src_imm=1.
  - ori with 0x8000 -> 0x00008000.
  - lui 0x1234 -> 0x12340000, alu_op=ADD.
- Load-use:
  - lw $8,0($2) then add $9,$8,$1 -> one bubble (ex_valid=0), id_stall high exactly one cycle, then the add appears with reg_dst_rd=1.
  - lw $8 then addi $9,$0,1 -> no stall.
  - lw $0 followed by a use of $0 -> no stall.
- Backpressure: ex_ready low 3 cycles with ex_valid=1 -> ex_* stable, id_stall=1 for 3 cycles, then the next instruction advances.
- Flush:
  - flush asserted during INTERLOCK -> bubble next cycle, FSM RUN, id_stall=0.
  - flush during HOLD -> held instruction discarded.
- Illegal and reset:
  - Opcode 0x3F -> illegal pulses one cycle, bubble loaded, no stall.
  - rst_n low mid-HOLD -> all outputs 0 asynchronously, and the first post-reset instruction decodes correctly.
